i2s_tx_sched: RTL
=================

Name: i2s_tx_sched

Overview:
- Sample scheduler in front of the I2S transmitter.
- Accepts stereo samples from the audio core over a valid/ready handshake and buffers them in a small FIFO.
- Feeds the transmitter's parallel sample inputs with a one-cycle valid strobe every MCLK_FRAME_DIVIDER clocks, so I2S frame timing is set by AMCLK, not by the source.
- Handles priming, underrun (mute) and overrun (drop), and reports sticky status flags.

Parameters:
- I2S_DATA_BITS, 24, width of each left/right sample.
- MCLK_FRAME_DIVIDER, 256, AMCLK cycles per output frame; power of 2, ≥4.
- FIFO_DEPTH, 4, sample-pair FIFO entries; power of 2, ≥2.
- PRIME_LEVEL, 2, FIFO fill needed before leaving PRIME; 1..FIFO_DEPTH.

Ports:
- AMCLK_i  in  1  audio master clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  scheduler enable.
- in_left_i  in  I2S_DATA_BITS  input left sample.
- in_right_i  in  I2S_DATA_BITS  input right sample.
- in_valid_i  in  1  input sample pair valid.
- in_ready_o  out  1  FIFO can accept a pair.
- APSDATA_LEFT_o  out  I2S_DATA_BITS  left sample to the transmitter.
- APSDATA_RIGHT_o  out  I2S_DATA_BITS  right sample to the transmitter.
- APDATA_VALID_o  out  1  one-cycle frame strobe to the transmitter.
- fill_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun_o  out  1  sticky underrun flag.
- overrun_o  out  1  sticky overrun flag.
- status_clr_i  in  1  clears both sticky flags.

Behaviour:
- Reset (async, reset_n=0): state IDLE, FIFO empty, frame counter 0.
  - All outputs 0, including in_ready_o, APDATA_VALID_o, fill_level_o and both flags.
- Push:
  - in_ready_o = enable_i && (fill < FIFO_DEPTH); combinational from registered state.
  - Push occurs on the AMCLK_i edge when in_valid_i && in_ready_o.
- Overrun:
  - in_valid_i && enable_i && !in_ready_o drops the pair and sets overrun_o.
  - in_valid_i while enable_i=0 is ignored; no flag is set.
- Frame counter:
  - Counts 0..MCLK_FRAME_DIVIDER-1 and wraps; runs only in PRIME and RUN.
  - tick = (counter == MCLK_FRAME_DIVIDER-1).
- State IDLE:
  - Counter held at 0, FIFO flushed, APSDATA outputs 0, no strobes.
  - enable_i=1 -> PRIME next cycle; the counter starts at 0 in that cycle.
- State PRIME:
  - On each tick, load 0 into both APSDATA outputs and assert APDATA_VALID_o on the same edge. The transmitter keeps framing, muted.
  - When fill ≥ PRIME_LEVEL at a tick: pop the head into the APSDATA outputs instead of zero, strobe, then -> RUN.
- State RUN:
  - On each tick with fill>0: pop the head into the APSDATA outputs and strobe.
  - On a tick with fill=0: load zeros, strobe, set underrun_o, -> PRIME.
- Strobe timing:
  - APDATA_VALID_o is registered and high for exactly one cycle per frame.
  - Strobe period is exactly MCLK_FRAME_DIVIDER cycles in PRIME/RUN, including across PRIME<->RUN transitions.
  - APSDATA outputs hold their value between strobes.
- Latency: a pair pushed into an empty FIFO in RUN appears at the next tick edge; the strobe rises in the cycle after that edge.
- Push and pop on the same edge: fill unchanged; data ordering preserved (FIFO order).
- Push is blocked when full even if a pop happens on the same edge; full is judged on the registered fill.
- enable_i falling in any state -> IDLE on the next edge:
  - FIFO flushed, counter 0, APSDATA outputs 0, no strobe.
  - A frame in progress is abandoned.
- Sticky flags: status_clr_i clears them on the next edge. A set event in the same cycle as the clear wins, so the flag stays 1.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; fill is computed with one extra bit.

Test Plan:
- Reset:
  - Assert reset_n=0 mid-RUN with fill=3 -> all outputs 0 immediately (async).
  - After release with enable_i=0 -> no strobes for 1000 cycles.
- Priming:
  - enable_i=1; push L/R 0x000001/0x000002 at cycle 10 and 0x000003/0x000004 at cycle 20.
  - Strobes at cycles 256 and 512, counted from the PRIME entry edge.
  - First strobe (cycle 256) carries 0x000001/0x000002 (fill≥2 at the tick); second carries 0x000003/0x000004; state RUN.
- Underrun:
  - In RUN with one queued pair and no further pushes -> next strobe carries the pair.
  - The strobe after that carries 0/0; underrun_o=1; later strobes stay zero until fill≥2.
  - Strobe period remains 256 throughout.
- Overrun:
  - Hold in_valid_i=1 with incrementing data for 10 cycles, no tick -> in_ready_o falls after 4 pushes; fill_level_o=4; overrun_o=1.
  - Next strobes deliver pushes 1..4 in order.
- Disable mid-operation:
  - Drop enable_i at counter=100 with fill=3 -> next edge: fill_level_o=0, APSDATA outputs 0, no strobe.
  - Re-enable -> first strobe 256 cycles later, muted.
- Status clear collision:
  - Assert status_clr_i in the same cycle as an overrun drop -> overrun_o stays 1.
  - status_clr_i alone the next cycle -> overrun_o=0.

Source files
------------

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched
// Buffers stereo sample pairs from the audio core in a small FIFO and presents
// one pair per I2S frame to the transmitter. A one-cycle strobe is issued every
// MCLK_FRAME_DIVIDER clocks. Frame timing comes from AMCLK, not from the source.
// PRIME mutes output until enough samples are queued. RUN plays from the FIFO
// and drops back to PRIME on underrun. Pushes into a full FIFO are dropped and
// flagged as overrun.
module i2s_tx_sched #(
    parameter int I2S_DATA_BITS      = 24,
    parameter int MCLK_FRAME_DIVIDER = 256,
    parameter int FIFO_DEPTH         = 4,
    parameter int PRIME_LEVEL        = 2
) (
    input  logic                          AMCLK_i,
    input  logic                          reset_n,
    input  logic                          enable_i,
    input  logic [I2S_DATA_BITS-1:0]      in_left_i,
    input  logic [I2S_DATA_BITS-1:0]      in_right_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [I2S_DATA_BITS-1:0]      APSDATA_LEFT_o,
    output logic [I2S_DATA_BITS-1:0]      APSDATA_RIGHT_o,
    output logic                          APDATA_VALID_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level_o,
    output logic                          underrun_o,
    output logic                          overrun_o,
    input  logic                          status_clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MCLK_FRAME_DIVIDER);
    localparam int PW = 2 * I2S_DATA_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PRIME_LVL = (AW+1)'(PRIME_LEVEL);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MCLK_FRAME_DIVIDER - 1);

    // Control state
    logic [1:0]               r_state;
    logic [CW-1:0]            r_cnt;
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [AW:0]              r_fill;
    logic                     r_valid;
    logic                     r_underrun;
    logic                     r_overrun;

    // Datapath state
    logic [PW-1:0]            r_mem [FIFO_DEPTH];
    logic [I2S_DATA_BITS-1:0] r_left;
    logic [I2S_DATA_BITS-1:0] r_right;

    // Combinational decode of the registered state
    logic [1:0]               w_state_nxt;
    logic                     w_active;
    logic                     w_tick;
    logic                     w_has_room;
    logic                     w_ready;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_empty;
    logic                     w_prime_ok;
    logic                     w_pop;
    logic                     w_underrun;
    logic [PW-1:0]            w_head;

    assign w_active   = (r_state == S_PRIME) || (r_state == S_RUN);

    // A tick in the same cycle that enable falls is discarded. The frame is
    // abandoned, so no strobe is issued.
    assign w_tick     = enable_i && w_active && (r_cnt == CNT_LAST);

    // Fullness is judged on the registered fill only. A pop on the same edge
    // does not open a slot for a push in that cycle.
    assign w_has_room = (r_fill < FULL_LVL);
    assign w_ready    = enable_i && w_has_room;
    assign w_push     = in_valid_i && w_ready;
    assign w_drop     = in_valid_i && enable_i && !w_has_room;

    assign w_empty    = (r_fill == '0);
    assign w_prime_ok = (r_fill >= PRIME_LVL);
    assign w_pop      = w_tick && (((r_state == S_RUN) && !w_empty) ||
                                   ((r_state == S_PRIME) && w_prime_ok));
    assign w_underrun = w_tick && (r_state == S_RUN) && w_empty;
    assign w_head     = r_mem[r_rd_ptr];

    // Ready is forced low while reset is asserted, so every output reads 0 in
    // reset even when enable_i is held high.
    assign in_ready_o      = reset_n && w_ready;
    assign APSDATA_LEFT_o  = r_left;
    assign APSDATA_RIGHT_o = r_right;
    assign APDATA_VALID_o  = r_valid;
    assign fill_level_o    = r_fill;
    assign underrun_o      = r_underrun;
    assign overrun_o       = r_overrun;

    // Next-state logic: enable low overrides everything and returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (!enable_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_PRIME;
                S_PRIME: if (w_tick && w_prime_ok) w_state_nxt = S_RUN;
                S_RUN:   if (w_underrun)           w_state_nxt = S_PRIME;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame counter: free-running in PRIME/RUN; the power-of-two width gives the wrap.
    // Because the counter is held at 0 in IDLE, PRIME starts counting from 0.
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!enable_i || !w_active) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // FIFO storage: data only, no reset needed
    always_ff @(posedge AMCLK_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_left_i, in_right_i};
        end
    end

    // FIFO pointers and occupancy; disable flushes everything
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (!enable_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Sample outputs: load head (or mute) on each tick, hold between ticks
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_left  <= '0;
            r_right <= '0;
        end else if (!enable_i) begin
            r_left  <= '0;
            r_right <= '0;
        end else if (w_tick) begin
            if (w_pop) begin
                {r_left, r_right} <= w_head;
            end else begin
                r_left  <= '0;
                r_right <= '0;
            end
        end
    end

    // Frame strobe: one cycle, registered alongside the sample load
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_tick;
        end
    end

    // Sticky status flags: a set event in the same cycle as a clear wins
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= (r_underrun && !status_clr_i) || w_underrun;
            r_overrun  <= (r_overrun  && !status_clr_i) || w_drop;
        end
    end

endmodule
